fifo_rd_streamer: RTL and testbench
===================================

FIFO_RD_STREAMER -- requirements
Module: fifo_rd_streamer

Interface
REQ-001 The module SHALL have parameter D_SIZE, default 16, giving the data word width.
REQ-002 The module SHALL have parameter PKT_LEN, default 4, giving beats per packet (legal range 2..256).
REQ-003 The module SHALL have parameter CNT_W, default 16, giving the packet counter width.
REQ-004 Port r_clk, input, 1 bit: the single clock, rising edge, which is the FIFO read clock.
REQ-005 Port i_r_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port i_empty, input, 1 bit: FIFO o_empty.
REQ-007 Port i_r_data, input, D_SIZE bits: FIFO o_r_data, valid in the same cycle whenever i_empty=0 (first-word-fall-through).
REQ-008 Port o_r_inc, output, 1 bit: pop strobe to the FIFO i_r_inc.
REQ-009 Port o_valid, output, 1 bit: downstream stream valid.
REQ-010 Port i_ready, input, 1 bit: downstream stream ready.
REQ-011 Port o_data, output, D_SIZE bits: downstream stream data.
REQ-012 Port o_last, output, 1 bit: marks the final beat of a PKT_LEN packet.
REQ-013 Port o_pkt_cnt, output, CNT_W bits: count of completed packets.
REQ-014 Port o_busy, output, 1 bit: high when the buffer is non-empty or a packet is partially sent.

Function
REQ-015 A 2-entry FIFO-order buffer SHALL hold popped words, with states EMPTY (0 entries), HALF (1 entry) and FULL (2 entries).
REQ-016 o_r_inc SHALL equal !i_empty && state!=FULL && !i_r_rst, with no combinational path from i_ready.
REQ-017 On o_r_inc=1, i_r_data SHALL be captured at the same r_clk edge into the tail entry.
REQ-018 A transfer SHALL occur when o_valid && i_ready, and it removes the head entry at that edge.
REQ-019 State transitions SHALL be: push-only raises the state by one; transfer-only lowers it by one; simultaneous push and transfer in HALF stays in HALF, with the new word becoming head after the old head leaves.
REQ-020 o_valid SHALL equal (state!=EMPTY), and o_data SHALL equal the head entry, both registered.
REQ-021 While o_valid=1 && i_ready=0, o_valid, o_data and o_last SHALL hold stable.
REQ-022 A beat counter, width clog2(PKT_LEN), SHALL increment on each transfer and wrap to 0 after PKT_LEN-1.
REQ-023 o_last SHALL equal o_valid && (beat counter == PKT_LEN-1).
REQ-024 o_pkt_cnt SHALL increment by 1 on each transfer with o_last=1, wrapping modulo 2^CNT_W.
REQ-025 o_busy SHALL equal (state!=EMPTY) || (beat counter!=0).
REQ-026 Steady-state throughput SHALL be one word per cycle when i_empty=0 and i_ready=1 continuously, with first-pop to o_valid latency of 1 cycle.
REQ-027 If i_empty rises mid-packet, the beat counter SHALL retain its value and the packet SHALL resume when data returns; no o_last is inserted.
REQ-028 When state=FULL, o_r_inc SHALL be 0 regardless of i_empty, so the FIFO is never popped without space.

Reset
REQ-029 On assertion of i_r_rst, without waiting for a clock, the module SHALL force: state=EMPTY, o_valid=0, o_data=0, o_last=0, beat counter=0, o_pkt_cnt=0, o_busy=0 and o_r_inc=0.
REQ-030 Reset mid-packet SHALL discard buffered words and the partial beat count; the first post-reset transfer is beat 0.
REQ-031 Deassertion SHALL take effect at the first r_clk edge after i_r_rst falls, and o_r_inc MAY assert in that cycle.

Structure
REQ-032 Package fifo_stream_pkg SHALL hold the buffer-state enum (EMPTY/HALF/FULL) and the default D_SIZE/PKT_LEN/CNT_W constants.
REQ-033 The 2-entry buffer SHALL be the sub-module fifo_skid_buf (push/pop/head/state), and the packet counters SHALL stay in fifo_rd_streamer.

Verification
REQ-034 Reset-then-stream: i_empty=0, data 0x0001..0x0008, i_ready=1 -> o_data 0x0001..0x0008 on consecutive cycles, o_last on 0x0004 and 0x0008, o_pkt_cnt=2.
REQ-035 Backpressure: 3 words available, i_ready=0 for 5 cycles -> exactly 2 pops, o_r_inc=0 while FULL, o_data held stable; after i_ready=1 the words arrive in order without loss.
REQ-036 Underflow mid-packet: 2 words, then i_empty=1 for 10 cycles, then 2 words -> o_last only on the 4th word, o_busy=1 throughout the gap.
REQ-037 Simultaneous push and transfer in HALF: ordering is preserved (head 0xA, new 0xB -> next o_data 0xB), state stays HALF.
REQ-038 Async reset mid-packet with state FULL -> outputs zero immediately without a clock edge; the next packet's o_last falls on its 4th beat.
REQ-039 Counter wrap with CNT_W=2: 5 packets -> o_pkt_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// Shared types and default sizes for the FIFO read-side streamer.
package fifo_stream_pkg;

  // Occupancy of the 2-entry skid buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  localparam int DEF_D_SIZE  = 16;
  localparam int DEF_PKT_LEN = 4;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry FIFO-order buffer between the FIFO pop side and the stream output.
// The head entry is held in its own register so it can drive o_data directly.
module fifo_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int D_SIZE = DEF_D_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [D_SIZE-1:0] push_data,
  input  logic              pop,
  output logic [D_SIZE-1:0] head,
  output buf_state_t        state
);

  buf_state_t        state_q, state_d;
  logic [D_SIZE-1:0] head_q, head_d;
  logic [D_SIZE-1:0] tail_q, tail_d;

  // Register occupancy and both entries; reset clears everything at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next occupancy and entry contents; a push+pop in HALF replaces the head
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = HALF;
        end
      end
      HALF: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d  = push_data;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign head  = head_q;
  assign state = state_q;

endmodule

// File: rtl/fifo_rd_streamer.sv
// Pops a first-word-fall-through FIFO into a valid/ready stream and frames
// the words into packets of PKT_LEN beats, counting completed packets.
module fifo_rd_streamer
  import fifo_stream_pkg::*;
#(
  parameter int D_SIZE  = DEF_D_SIZE,
  parameter int PKT_LEN = DEF_PKT_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              r_clk,
  input  logic              i_r_rst,
  input  logic              i_empty,
  input  logic [D_SIZE-1:0] i_r_data,
  output logic              o_r_inc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [D_SIZE-1:0] o_data,
  output logic              o_last,
  output logic [CNT_W-1:0]  o_pkt_cnt,
  output logic              o_busy
);

  localparam int BEAT_W = $clog2(PKT_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  buf_state_t        buf_state;
  logic              transfer;
  logic [BEAT_W-1:0] beat_cnt;

  // Pop only when there is room; the decision never looks at i_ready
  assign o_r_inc  = !i_empty && (buf_state != FULL) && !i_r_rst;
  assign o_valid  = (buf_state != EMPTY);
  assign transfer = o_valid && i_ready;
  assign o_last   = o_valid && (beat_cnt == LAST_BEAT);
  assign o_busy   = (buf_state != EMPTY) || (beat_cnt != '0);

  fifo_skid_buf #(
    .D_SIZE(D_SIZE)
  ) u_buf (
    .clk      (r_clk),
    .rst      (i_r_rst),
    .push     (o_r_inc),
    .push_data(i_r_data),
    .pop      (transfer),
    .head     (o_data),
    .state    (buf_state)
  );

  // Beat position within the current packet; holds across FIFO underflow
  always_ff @(posedge r_clk or posedge i_r_rst) begin
    if (i_r_rst) begin
      beat_cnt <= '0;
    end else if (transfer) begin
      if (beat_cnt == LAST_BEAT) beat_cnt <= '0;
      else                       beat_cnt <= beat_cnt + BEAT_W'(1);
    end
  end

  // Completed packet count, wrapping at the counter width
  always_ff @(posedge r_clk or posedge i_r_rst) begin
    if (i_r_rst) begin
      o_pkt_cnt <= '0;
    end else if (transfer && o_last) begin
      o_pkt_cnt <= o_pkt_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer with a small FWFT FIFO source model.
module tb_fifo_rd_streamer;
  import fifo_stream_pkg::*;

  localparam int D_SIZE  = 16;
  localparam int PKT_LEN = 4;
  localparam int CNT_W   = 2;

  logic              r_clk = 1'b0;
  logic              i_r_rst;
  logic              i_empty;
  logic [D_SIZE-1:0] i_r_data;
  logic              o_r_inc;
  logic              o_valid;
  logic              i_ready;
  logic [D_SIZE-1:0] o_data;
  logic              o_last;
  logic [CNT_W-1:0]  o_pkt_cnt;
  logic              o_busy;

  logic [D_SIZE-1:0] src_mem [0:63];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int errors = 0;
  int checks = 0;
  int start_ptr;
  int exp_pkt;

  fifo_rd_streamer #(
    .D_SIZE (D_SIZE),
    .PKT_LEN(PKT_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .r_clk    (r_clk),
    .i_r_rst  (i_r_rst),
    .i_empty  (i_empty),
    .i_r_data (i_r_data),
    .o_r_inc  (o_r_inc),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_last   (o_last),
    .o_pkt_cnt(o_pkt_cnt),
    .o_busy   (o_busy)
  );

  // Free-running read clock
  always #5 r_clk = ~r_clk;

  // FWFT source: the word at the read pointer is visible whenever non-empty
  assign i_empty  = (rd_ptr == wr_ptr);
  assign i_r_data = src_mem[rd_ptr % 64];

  // Source read pointer advances on every pop strobe
  always @(posedge r_clk) begin
    if (o_r_inc) rd_ptr <= rd_ptr + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ready, input int cycles);
    i_ready = ready;
    repeat (cycles) begin
      @(posedge r_clk);
      #1;
    end
  endtask

  task automatic loadWord(input logic [D_SIZE-1:0] w);
    src_mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  initial begin
    i_r_rst = 1'b1;
    i_ready = 1'b0;
    #3;
    $display("[TB] reset state");
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_data", 32'(o_data), 32'd0);
    checkOutput("rst_last", 32'(o_last), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_pkt", 32'(o_pkt_cnt), 32'd0);
    for (int k = 1; k <= 8; k++) loadWord(16'(k));
    #1;
    checkOutput("rst_rinc", 32'(o_r_inc), 32'd0);
    @(posedge r_clk);
    #1;
    i_r_rst = 1'b0;

    $display("[TB] reset-then-stream");
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1);
      checkOutput("s_valid", 32'(o_valid), 32'd1);
      checkOutput("s_data", 32'(o_data), 32'(k));
      checkOutput("s_last", 32'(o_last), 32'(k % 4 == 0));
    end
    applyStimulus(1'b1, 1);
    checkOutput("s_end_valid", 32'(o_valid), 32'd0);
    checkOutput("s_pkt", 32'(o_pkt_cnt), 32'd2);
    checkOutput("s_busy", 32'(o_busy), 32'd0);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 0);
    start_ptr = rd_ptr;
    loadWord(16'h0011);
    loadWord(16'h0012);
    loadWord(16'h0013);
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1'b0, 1);
      checkOutput("bp_valid", 32'(o_valid), 32'd1);
      checkOutput("bp_data", 32'(o_data), 32'h11);
      if (c >= 2) checkOutput("bp_rinc_full", 32'(o_r_inc), 32'd0);
    end
    checkOutput("bp_pops", 32'(rd_ptr - start_ptr), 32'd2);
    applyStimulus(1'b1, 1);
    checkOutput("bp_data2", 32'(o_data), 32'h12);
    applyStimulus(1'b1, 1);
    checkOutput("bp_data3", 32'(o_data), 32'h13);
    checkOutput("bp_last3", 32'(o_last), 32'd0);
    loadWord(16'h0014);
    applyStimulus(1'b1, 1);
    checkOutput("bp_data4", 32'(o_data), 32'h14);
    checkOutput("bp_last4", 32'(o_last), 32'd1);
    applyStimulus(1'b1, 1);
    checkOutput("bp_pkt", 32'(o_pkt_cnt), 32'd3);
    checkOutput("bp_valid_end", 32'(o_valid), 32'd0);

    $display("[TB] underflow mid-packet");
    loadWord(16'h0021);
    loadWord(16'h0022);
    applyStimulus(1'b1, 1);
    checkOutput("uf_data1", 32'(o_data), 32'h21);
    applyStimulus(1'b1, 1);
    checkOutput("uf_data2", 32'(o_data), 32'h22);
    checkOutput("uf_last2", 32'(o_last), 32'd0);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 1);
      checkOutput("uf_gap_busy", 32'(o_busy), 32'd1);
      checkOutput("uf_gap_valid", 32'(o_valid), 32'd0);
    end
    loadWord(16'h0023);
    loadWord(16'h0024);
    applyStimulus(1'b1, 1);
    checkOutput("uf_data3", 32'(o_data), 32'h23);
    checkOutput("uf_last3", 32'(o_last), 32'd0);
    applyStimulus(1'b1, 1);
    checkOutput("uf_data4", 32'(o_data), 32'h24);
    checkOutput("uf_last4", 32'(o_last), 32'd1);
    applyStimulus(1'b1, 1);
    checkOutput("uf_pkt_wrap", 32'(o_pkt_cnt), 32'd0);
    checkOutput("uf_busy_end", 32'(o_busy), 32'd0);

    $display("[TB] push and transfer in HALF");
    applyStimulus(1'b0, 0);
    loadWord(16'h000A);
    applyStimulus(1'b0, 1);
    checkOutput("ht_dataA", 32'(o_data), 32'hA);
    loadWord(16'h000B);
    applyStimulus(1'b1, 1);
    checkOutput("ht_dataB", 32'(o_data), 32'hB);
    checkOutput("ht_state", 32'(dut.buf_state), 32'(HALF));
    applyStimulus(1'b0, 1);
    checkOutput("ht_holdB", 32'(o_data), 32'hB);
    checkOutput("ht_validB", 32'(o_valid), 32'd1);
    applyStimulus(1'b1, 1);
    checkOutput("ht_valid_end", 32'(o_valid), 32'd0);
    checkOutput("ht_busy_partial", 32'(o_busy), 32'd1);

    $display("[TB] async reset while FULL");
    applyStimulus(1'b0, 0);
    loadWord(16'h0031);
    loadWord(16'h0032);
    loadWord(16'h0033);
    applyStimulus(1'b0, 2);
    checkOutput("ar_state", 32'(dut.buf_state), 32'(FULL));
    checkOutput("ar_rinc_full", 32'(o_r_inc), 32'd0);
    #2;
    i_r_rst = 1'b1;
    #1;
    checkOutput("ar_valid", 32'(o_valid), 32'd0);
    checkOutput("ar_data", 32'(o_data), 32'd0);
    checkOutput("ar_last", 32'(o_last), 32'd0);
    checkOutput("ar_busy", 32'(o_busy), 32'd0);
    checkOutput("ar_rinc", 32'(o_r_inc), 32'd0);
    @(posedge r_clk);
    #1;
    i_r_rst = 1'b0;
    i_ready = 1'b1;
    loadWord(16'h0034);
    loadWord(16'h0035);
    loadWord(16'h0036);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1);
      checkOutput("ar_pdata", 32'(o_data), 32'(16'h0033 + k));
      checkOutput("ar_plast", 32'(o_last), 32'(k == 3));
    end
    applyStimulus(1'b1, 1);
    checkOutput("ar_pkt", 32'(o_pkt_cnt), 32'd1);

    $display("[TB] packet counter wrap");
    exp_pkt = 1;
    for (int k = 0; k < 16; k++) loadWord(16'(16'h0040 + k));
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b1, 1);
      checkOutput("cw_data", 32'(o_data), 32'(16'h0040 + k - 1));
      checkOutput("cw_last", 32'(o_last), 32'(k % 4 == 0));
      if ((k % 4 == 1) && (k > 1)) begin
        exp_pkt = (exp_pkt + 1) % 4;
        checkOutput("cw_pkt", 32'(o_pkt_cnt), 32'(exp_pkt));
      end
    end
    applyStimulus(1'b1, 1);
    exp_pkt = (exp_pkt + 1) % 4;
    checkOutput("cw_pkt_final", 32'(o_pkt_cnt), 32'(exp_pkt));
    checkOutput("cw_valid_end", 32'(o_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
